// File: rtl/wb_slave_router.sv
// wb_slave_router: registered Wishbone classic router from the user-project
// master port to three slaves (0x30 RAM, 0x34 matmul, 0x38 external memory).
// One cycle is in flight at a time. Unmapped addresses get a local ack with
// zero data. Define WB_ROUTER_TIMEOUT_EN to terminate a hung slave after
// TIMEOUT_CYCLES request cycles with ERR_DATA and an err_o pulse.
module wb_slave_router #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        wbs_clk_i,
    input  logic        wbs_rst_n_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [2:0]  s_stb_o,
    output logic [2:0]  s_cyc_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [2:0]  s_ack_i,
    input  logic [31:0] s_dat0_i,
    input  logic [31:0] s_dat1_i,
    input  logic [31:0] s_dat2_i,
    output logic        busy_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  stb_q, stb_d;     // one-hot target, nonzero only in REQ
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        ack_q, ack_d;
    logic [31:0] rdat_q, rdat_d;
    logic        busy_q, busy_d;

    logic [2:0]  tgt;
    logic [31:0] slv_rdat;
    logic        req_vld;
    logic        ack_hit;

`ifdef WB_ROUTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          expired;

    // Last permitted REQ cycle: counter has seen TIMEOUT_CYCLES-1 ack-less cycles.
    assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    assign req_vld = wbs_cyc_i & wbs_stb_i;
    assign ack_hit = |(s_ack_i & stb_q);

    // Address decode on the top byte into a one-hot slave select.
    always_comb begin
        tgt = 3'b000;
        case (wbs_adr_i[31:24])
            8'h30:   tgt = 3'b001;
            8'h34:   tgt = 3'b010;
            8'h38:   tgt = 3'b100;
            default: tgt = 3'b000;
        endcase
    end

    // Read-data mux steered by the active strobe.
    always_comb begin
        slv_rdat = 32'h0;
        case (stb_q)
            3'b001:  slv_rdat = s_dat0_i;
            3'b010:  slv_rdat = s_dat1_i;
            3'b100:  slv_rdat = s_dat2_i;
            default: slv_rdat = 32'h0;
        endcase
    end

    // Next-state and next-output computation for the IDLE/REQ/RESP machine.
    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        ack_d   = 1'b0;
        rdat_d  = rdat_q;
`ifdef WB_ROUTER_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_vld) begin
                    we_d   = wbs_we_i;
                    sel_d  = wbs_sel_i;
                    adr_d  = wbs_adr_i;
                    wdat_d = wbs_dat_i;
                    if (tgt != 3'b000) begin
                        state_d = REQ;
                        stb_d   = tgt;
`ifdef WB_ROUTER_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        // Unmapped: terminate locally, writes go nowhere.
                        state_d = RESP;
                        ack_d   = 1'b1;
                        rdat_d  = 32'h0;
                    end
                end
            end
            REQ: begin
                if (!req_vld) begin
                    // Master abort beats a same-cycle slave ack.
                    state_d = IDLE;
                    stb_d   = 3'b000;
                end else if (ack_hit) begin
                    state_d = RESP;
                    stb_d   = 3'b000;
                    ack_d   = 1'b1;
                    rdat_d  = we_q ? 32'h0 : slv_rdat;
`ifdef WB_ROUTER_TIMEOUT_EN
                end else if (expired) begin
                    state_d = RESP;
                    stb_d   = 3'b000;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    if (!we_q) rdat_d = ERR_DATA;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
`endif
                end
            end
            default: state_d = IDLE;   // RESP: ack is out this cycle, master not sampled
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
        if (!wbs_rst_n_i) begin
            state_q <= IDLE;
            stb_q   <= 3'b000;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= 32'h0;
            wdat_q  <= 32'h0;
            ack_q   <= 1'b0;
            rdat_q  <= 32'h0;
            busy_q  <= 1'b0;
`ifdef WB_ROUTER_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
            busy_q  <= busy_d;
`ifdef WB_ROUTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign s_stb_o   = stb_q;
    assign s_cyc_o   = stb_q;
    assign s_we_o    = we_q;
    assign s_sel_o   = sel_q;
    assign s_adr_o   = adr_q;
    assign s_dat_o   = wdat_q;
    assign busy_o    = busy_q;
`ifdef WB_ROUTER_TIMEOUT_EN
    assign err_o     = err_q;
`else
    assign err_o     = 1'b0;
`endif
endmodule

// File: tb/tb_wb_slave_router.sv
// Scoreboard bench for wb_slave_router. Stimulus acts as master and slaves,
// predicting each response from the address map and slave latency and pushing
// it into a queue; a negedge monitor pops and compares on every wbs_ack_o.
module tb_wb_slave_router;
`ifdef WB_ROUTER_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 0;        // 0: no timeout in the model
`endif
    localparam int TMO_P = (TMO == 0) ? 255 : TMO;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [2:0]  s_stb_o, s_cyc_o;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [2:0]  s_ack_i = 3'b000;
    logic [31:0] s_dat0_i = 32'h0, s_dat1_i = 32'h0, s_dat2_i = 32'h0;
    logic        busy_o, err_o;

    wb_slave_router #(.TIMEOUT_CYCLES(TMO_P), .ERR_DATA(32'hDEADBEEF)) dut (
        .wbs_clk_i(clk), .wbs_rst_n_i(rst_n),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i),
        .s_dat0_i(s_dat0_i), .s_dat1_i(s_dat1_i), .s_dat2_i(s_dat2_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        chk_dat;
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          vecs = 0, errs = 0;
    int          cyc_n = 0;
    bit          in_resp = 1'b0;
    logic [31:0] last_rd = 32'h0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (rst_n && wbs_ack_o) begin
            if (sb.size() == 0) chk("unexpected_ack", 128'(wbs_ack_o), 128'(0));
            else begin
                e = sb.pop_front();
                chk("ack_cycle", 128'(cyc_n), 128'(e.cyc));
                if (e.chk_dat) chk("rd_data", 128'(wbs_dat_o), 128'(e.dat));
                chk("err_flag", 128'(err_o), 128'(e.err));
            end
        end else if (rst_n && err_o) begin
            chk("err_without_ack", 128'(err_o), 128'(0));
        end
    end

    function automatic logic [2:0] onehot(input logic [31:0] a);
        case (a[31:24])
            8'h30:   return 3'b001;
            8'h34:   return 3'b010;
            8'h38:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic drive_slave_data(input logic [2:0] oh, input logic [31:0] d);
        s_dat0_i = $urandom; s_dat1_i = $urandom; s_dat2_i = $urandom;
        if (oh[0]) s_dat0_i = d;
        if (oh[1]) s_dat1_i = d;
        if (oh[2]) s_dat2_i = d;
    endtask

    // One master cycle; slave acks after 'lat' wait states with 'rd'.
    // Returns on the negedge where the ack is visible (DUT in RESP).
    task automatic txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] wd, input int lat, input logic [31:0] rd);
        int n, k_end;
        bit tmo;
        logic [2:0] oh;
        exp_t x;
        oh = onehot(adr);
        n  = cyc_n + (in_resp ? 2 : 1);   // edge that samples the request
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = wd;
        tmo = 1'b0;
        if (oh == 3'b000)                   k_end = 0;
        else if (TMO != 0 && lat + 1 > TMO) begin k_end = TMO; tmo = 1'b1; end
        else                                k_end = lat + 1;
        x.cyc = n + k_end;
        x.err = tmo;
        x.chk_dat = !we;
        x.dat = (oh == 3'b000) ? 32'h0 : (tmo ? 32'hDEADBEEF : rd);
        sb.push_back(x);
        if (!we) last_rd = x.dat;
        @(negedge clk);
        while (cyc_n < n) @(negedge clk);
        for (int k = 1; k <= k_end; k++) begin
            chk("req_stb", {s_cyc_o, s_stb_o}, {oh, oh});
            chk("req_fields", {busy_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}, {1'b1, we, sel, adr, wd});
            wbs_adr_i = $urandom; wbs_dat_i = $urandom;
            wbs_we_i = 1'($urandom); wbs_sel_i = 4'($urandom);
            drive_slave_data(oh, $urandom);
            s_ack_i = 3'($urandom) & ~oh;
            if (k == lat + 1) begin
                s_ack_i = s_ack_i | oh;
                drive_slave_data(oh, rd);
            end
            @(negedge clk);
        end
        s_ack_i = 3'b000;
        chk("resp_stb", {s_cyc_o, s_stb_o}, 6'b0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        in_resp = 1'b1;
    endtask

    task automatic idle(input int g);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        repeat (g) @(negedge clk);
        if (g > 0) in_resp = 1'b0;
    endtask

    // Master drops stb in REQ cycle 2 while the slave acks that same cycle.
    task automatic abort_txn(input logic [31:0] adr);
        logic [2:0] oh;
        oh = onehot(adr);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = adr;
        @(negedge clk);
        chk("abort_req_stb", 128'(s_stb_o), 128'(oh));
        @(negedge clk);
        wbs_stb_i = 1'b0;
        s_ack_i = oh;
        drive_slave_data(oh, 32'h5A5A_1234);
        @(negedge clk);
        chk("abort_idle", {busy_o, s_stb_o, s_cyc_o}, 7'b0);
        chk("abort_dat_kept", 128'(wbs_dat_o), 128'(last_rd));
        s_ack_i = 3'b000; wbs_cyc_i = 1'b0;
        in_resp = 1'b0;
    endtask

    task automatic reset_txn(input logic [31:0] adr);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_sel_i = 4'hF; wbs_adr_i = adr; wbs_dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_req_stb", 128'(s_stb_o), 128'(onehot(adr)));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {wbs_ack_o, wbs_dat_o, s_stb_o, s_cyc_o, s_we_o, s_sel_o,
                                s_adr_o, s_dat_o, busy_o, err_o}, 128'(0));
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = 32'h0;
        in_resp = 1'b0;
    endtask

    function automatic logic [31:0] rand_adr();
        logic [7:0] hi;
        case ($urandom_range(0, 3))
            0: hi = 8'h30;
            1: hi = 8'h34;
            2: hi = 8'h38;
            default: begin
                hi = 8'($urandom);
                while (hi == 8'h30 || hi == 8'h34 || hi == 8'h38) hi = 8'($urandom);
            end
        endcase
        return {hi, 24'($urandom)};
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {wbs_ack_o, wbs_dat_o, s_stb_o, s_cyc_o, s_we_o, s_sel_o,
                              s_adr_o, s_dat_o, busy_o, err_o}, 128'(0));
        rst_n = 1'b1;
        idle(1);

        txn(32'h3000_0010, 1'b1, 4'hF, 32'h1234_5678, 0, 32'h0);
        idle(1);
        txn(32'h3800_0004, 1'b0, 4'hF, 32'h0, 3, 32'hCAFE_F00D);
        idle(1);
        abort_txn(32'h3400_0000);
        idle(1);
        txn(32'h2000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0);
        idle(1);
        reset_txn(32'h3400_0000);
        idle(1);
`ifdef WB_ROUTER_TIMEOUT_EN
        txn(32'h3400_0000, 1'b0, 4'hF, 32'h0, 100, 32'h0);
        idle(1);
        txn(32'h3400_0000, 1'b0, 4'hF, 32'h0, TMO - 1, 32'h0000_0007);
        idle(1);
        txn(32'h3000_0000, 1'b1, 4'h3, 32'h0BAD_0BAD, 100, 32'h0);
        idle(1);
`endif
        for (int i = 0; i < 80; i++) begin
            txn(rand_adr(), 1'($urandom), 4'($urandom), $urandom,
                $urandom_range(0, (TMO != 0) ? 6 : 3), $urandom);
            idle($urandom_range(0, 2));
        end

        idle(4);
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
